// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch front end.
package fetch_pkg;
  localparam int          XLEN_DEF   = 64;
  localparam int          QDEPTH_DEF = 4;
  localparam int          QPTR_BITS  = $clog2(QDEPTH_DEF);
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO; flush empties it in one edge.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    head, tail;
  logic             do_push, do_pop;

  assign valid   = (count != '0);
  assign dout    = store[head];
  assign do_pop  = pop && valid;
  // Push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) store[tail] <= din;
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: instruction memory, free-running fetch PC and FWFT queue to decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              ADDR_BITS = 10,
  parameter int              QDEPTH    = QDEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_en,
  input  logic [ADDR_BITS-1:0]        ld_addr,
  input  logic [31:0]                 ld_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_pc,
  output logic [31:0]                 out_instr,
  output logic [XLEN-1:0]             fetch_pc,
  output logic [$clog2(QDEPTH+1)-1:0] q_count
);
  localparam int CW = $clog2(QDEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [31:0] mem [1<<ADDR_BITS];
  logic [31:0] word;
  logic        in_range, push, pop;
  entry_t      tail_in, head;

  // Not reset: boot code loaded during reset must survive it.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign in_range = (fetch_pc[XLEN-1:ADDR_BITS+2] == '0);
  assign word     = in_range ? mem[fetch_pc[ADDR_BITS+1:2]] : NOP_INSTR;

  assign pop  = out_valid && out_ready;
  assign push = !reset && !redirect_valid && ((q_count < CW'(QDEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (reset)               fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc & ~XLEN'(3);
    else if (push)           fetch_pc <= fetch_pc + XLEN'(4);
  end

  assign tail_in = '{pc: fetch_pc, instr: word};

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (tail_in),
    .dout  (head),
    .valid (out_valid),
    .count (q_count)
  );

  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed vector bench for instr_fetch_queue with a few hand-written corner sequences.
module tb_instr_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] NEW5 = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset, ld_en, redirect_valid, out_ready;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc, fetch_pc;
  logic [31:0] out_instr;
  logic [2:0]  q_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_mem [32];

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_pc(fetch_pc), .q_count(q_count)
  );

  typedef struct {
    string       name;
    logic        rst, rdv, rdy, ld;
    logic [63:0] rpc;
    logic [9:0]  la;
    logic [31:0] ldd;
    logic        e_v;
    logic [63:0] e_pc, e_fpc;
    logic [31:0] e_in;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] m(int i);
    return exp_mem[i];
  endfunction

  function automatic vec_t V(string name, logic rst, logic rdv, logic [63:0] rpc, logic rdy,
                             logic ld, logic [9:0] la, logic [31:0] ldd, logic e_v,
                             logic [63:0] e_pc, logic [31:0] e_in, logic [63:0] e_fpc,
                             logic [2:0] e_cnt);
    vec_t v;
    v.name = name; v.rst = rst; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy; v.ld = ld;
    v.la = la; v.ldd = ldd; v.e_v = e_v; v.e_pc = e_pc; v.e_in = e_in;
    v.e_fpc = e_fpc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(string name, logic e_v, logic [63:0] e_pc, logic [31:0] e_in,
                         logic [63:0] e_fpc, logic [2:0] e_cnt);
    chk({name, ".out_valid"}, 64'(out_valid), 64'(e_v));
    chk({name, ".out_pc"},    out_pc,          e_pc);
    chk({name, ".out_instr"}, 64'(out_instr),  64'(e_in));
    chk({name, ".fetch_pc"},  fetch_pc,        e_fpc);
    chk({name, ".q_count"},   64'(q_count),    64'(e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    exp_mem[0] = 32'h0020_8233; exp_mem[1] = 32'h4042_8333;
    exp_mem[2] = 32'h0062_03B3; exp_mem[3] = 32'h0093_8413;
    for (int i = 4; i < 32; i++) exp_mem[i] = 32'hA000_0000 | 32'(i);

    // Code is loaded while reset is held.
    #1;
    for (int i = 0; i < 32; i++) begin
      ld_en = 1'b1; ld_addr = 10'(i); ld_data = exp_mem[i];
      step();
    end
    ld_en = 1'b0;

    //          name      rst rdv rpc          rdy ld la ldd   e_v e_pc       e_in   e_fpc      cnt
    vecs.push_back(V("rst0",   1, 0, 64'h0,    1, 0, 0, 0,    0, 64'h0,     NOP,   64'h0,     0));
    vecs.push_back(V("rst1",   1, 0, 64'h0,    1, 0, 0, 0,    0, 64'h0,     NOP,   64'h0,     0));
    vecs.push_back(V("strm0",  0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h0,     m(0),  64'h4,     1));
    vecs.push_back(V("strm1",  0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h4,     m(1),  64'h8,     1));
    vecs.push_back(V("strm2",  0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h8,     m(2),  64'hC,     1));
    vecs.push_back(V("strm3",  0, 0, 64'h0,    1, 0, 0, 0,    1, 64'hC,     m(3),  64'h10,    1));
    // Backpressure fill then drain
    vecs.push_back(V("bp_rst", 1, 0, 64'h0,    0, 0, 0, 0,    0, 64'h0,     NOP,   64'h0,     0));
    vecs.push_back(V("bp1",    0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'h4,     1));
    vecs.push_back(V("bp2",    0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'h8,     2));
    vecs.push_back(V("bp3",    0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'hC,     3));
    vecs.push_back(V("bp4",    0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'h10,    4));
    vecs.push_back(V("bp_hold",0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'h10,    4));
    vecs.push_back(V("dr1",    0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h4,     m(1),  64'h14,    4));
    vecs.push_back(V("dr2",    0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h8,     m(2),  64'h18,    4));
    vecs.push_back(V("dr3",    0, 0, 64'h0,    1, 0, 0, 0,    1, 64'hC,     m(3),  64'h1C,    4));
    vecs.push_back(V("dr4",    0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h10,    m(4),  64'h20,    4));
    // Redirect with 3 entries queued; low target bits dropped
    vecs.push_back(V("q3_rst", 1, 0, 64'h0,    0, 0, 0, 0,    0, 64'h0,     NOP,   64'h0,     0));
    vecs.push_back(V("q3_a",   0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'h4,     1));
    vecs.push_back(V("q3_b",   0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'h8,     2));
    vecs.push_back(V("q3_c",   0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h0,     m(0),  64'hC,     3));
    vecs.push_back(V("rd_fl",  0, 1, 64'h23,   0, 0, 0, 0,    0, 64'h0,     NOP,   64'h20,    0));
    vecs.push_back(V("rd_tgt", 0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h20,    m(8),  64'h24,    1));
    // Out-of-range fetch returns NOP
    vecs.push_back(V("oor_fl", 0, 1, 64'h1000, 1, 0, 0, 0,    0, 64'h0,     NOP,   64'h1000,  0));
    vecs.push_back(V("oor0",   0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h1000,  NOP,   64'h1004,  1));
    vecs.push_back(V("oor1",   0, 0, 64'h0,    1, 0, 0, 0,    1, 64'h1004,  NOP,   64'h1008,  1));
    // Load racing a fetch of the same word: old data queued, new data after redirect
    vecs.push_back(V("ld_fl",  0, 1, 64'h14,   1, 0, 0, 0,    0, 64'h0,     NOP,   64'h14,    0));
    vecs.push_back(V("ld_rbw", 0, 0, 64'h0,    0, 1, 5, NEW5, 1, 64'h14,    m(5),  64'h18,    1));
    vecs.push_back(V("ld_fl2", 0, 1, 64'h14,   0, 0, 0, 0,    0, 64'h0,     NOP,   64'h14,    0));
    vecs.push_back(V("ld_new", 0, 0, 64'h0,    0, 0, 0, 0,    1, 64'h14,    NEW5,  64'h18,    1));

    foreach (vecs[k]) begin
      reset = vecs[k].rst; redirect_valid = vecs[k].rdv; redirect_pc = vecs[k].rpc;
      out_ready = vecs[k].rdy; ld_en = vecs[k].ld; ld_addr = vecs[k].la; ld_data = vecs[k].ldd;
      step();
      if (vecs[k].ld) exp_mem[vecs[k].la] = vecs[k].ldd;
      chk_all(vecs[k].name, vecs[k].e_v, vecs[k].e_pc, vecs[k].e_in, vecs[k].e_fpc, vecs[k].e_cnt);
    end
    ld_en = 1'b0; redirect_valid = 1'b0;

    // Full queue, one-cycle reset, then restart from RESET_PC with memory intact
    out_ready = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("full.q_count", 64'(q_count), 64'd4);
    reset = 1'b1; step();
    chk_all("mid_rst", 1'b0, 64'h0, NOP, 64'h0, 3'd0);
    reset = 1'b0; out_ready = 1'b1;
    begin
      int lat = 0;
      while (!out_valid && lat < 8) begin step(); lat++; end
      chk("restart.latency", 64'(lat), 64'd1);
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("restart.pc%0d", i),    out_pc,          64'(4 * i));
      chk($sformatf("restart.instr%0d", i), 64'(out_instr),  64'(exp_mem[i]));
      step();
    end

    // PC wraps modulo 2^64
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; step();
    redirect_valid = 1'b0; step();
    chk_all("wrap0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'h0, 3'd1);
    step();
    chk_all("wrap1", 1'b1, 64'h0, exp_mem[0], 64'h4, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Parametrised instruction-fetch front end for the pipelined core. It holds an internal instruction memory of 2^ADDR_BITS 32-bit words, with a word-write load port for the bench or boot loader, and a free-running fetch PC. Each fetched word is pushed with its PC into a small first-word-fall-through queue that feeds decode through a valid/ready handshake. Branch/jump redirects flush the queue and reload the PC.

Parameters:
XLEN, 64, PC width
ADDR_BITS, 10, word-address bits of instruction memory (1024 words)
QDEPTH, 4, fetch queue entries; power of two, at least 2
RESET_PC, 0, fetch PC after reset
NOP_INSTR, 32'h00000013, word returned for out-of-range fetches (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
ld_en  in  1  write enable for instruction memory
ld_addr  in  ADDR_BITS  word address to write
ld_data  in  32  instruction word to write
redirect_valid  in  1  flush queue and load new PC
redirect_pc  in  XLEN  redirect target (bits [1:0] ignored)
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head entry
out_instr  out  32  instruction of head entry
fetch_pc  out  XLEN  next PC to be fetched
q_count  out  $clog2(QDEPTH+1)  occupied entries

Behaviour:
- Reset, sampled on clk edge, has priority over everything.
  - fetch_pc=RESET_PC, queue empty, q_count=0, out_valid=0.
  - out_pc=0 and out_instr=NOP_INSTR while empty.
  - Instruction memory is not cleared.
- Reset mid-operation discards all queued entries within 1 cycle.
- Memory read is combinational on fetch_pc[ADDR_BITS+1:2].
  - If fetch_pc >= 4*2^ADDR_BITS, the fetched word is NOP_INSTR.
- Load: on an edge with ld_en=1, mem[ld_addr] <= ld_data.
  - A same-cycle fetch of the same word gets the old data (read-before-write).
  - Already-queued entries are never patched; software must redirect after reloading code.
- Pop occurs when out_valid && out_ready.
- Push occurs when !reset && !redirect_valid && (q_count<QDEPTH || pop).
  - On push: entry {fetch_pc, word} is written at tail and fetch_pc += 4, wrapping modulo 2^XLEN.
- Simultaneous push and pop on a full queue is allowed; q_count is unchanged.
- Simultaneous push and pop on an empty queue cannot occur, because out_valid=0.
- Queue is first-word-fall-through.
  - out_valid = (q_count != 0); out_pc and out_instr reflect the head.
  - Latency: a word pushed on edge N is visible after edge N, so out_valid rises 1 cycle after reset is released.
- Throughput is 1 instruction per cycle with out_ready held at 1.
- Redirect (redirect_valid=1, no reset):
  - Queue flushed: q_count=0, head/tail pointers reset.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No push that cycle; any pop that cycle is void, and the consumer must ignore the head when issuing a redirect.
  - First target entry is visible 2 edges after redirect assertion (edge 1 flushes, edge 2 pushes).
- Priority: reset > redirect > push/pop. Load is independent and is performed even during reset or redirect.
- Head/tail pointers wrap modulo QDEPTH. q_count never exceeds QDEPTH.
- Backpressure: with out_ready=0, fetch_pc stops advancing once the queue is full.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR default constant
  - typedef fetch_entry_t {pc[XLEN-1:0], instr[31:0]}
  - local constant QPTR_BITS = $clog2(QDEPTH)
- One sub-module, fetch_fifo: a synchronous FWFT FIFO with parameters WIDTH and DEPTH, plus push, pop, flush and count.
- The top level holds the memory array, fetch_pc register and push logic.

Test Plan:
1. Load words 0-3 = 0x00208233, 0x40428333, 0x006203B3, 0x00938413, then reset 2 cycles, out_ready=1 -> out_valid rises 1 cycle after reset drops; out_pc 0,4,8,12 with matching words on consecutive cycles.
2. out_ready=0 after reset -> q_count 1,2,3,4 then holds at 4; fetch_pc=0x10; head stays pc 0. Raising ready gives pcs 0,4,8,... with no loss or duplicate.
3. Queue holding 3 entries, redirect_pc=0x23 -> next cycle q_count=0, out_valid=0, fetch_pc=0x20; following cycle out_pc=0x20, out_instr=mem[8].
4. ADDR_BITS=10, redirect to 0x1000 -> out_instr=0x00000013, out_pc=0x1000; next entry pc 0x1004 is also 0x00000013.
5. ld_en with ld_addr=5 on the edge where fetch_pc=0x14 -> queued word is old mem[5]; after redirect to 0x14, new ld_data appears.
6. Full queue, then reset for 1 cycle -> next cycle out_valid=0, q_count=0, fetch_pc=RESET_PC; memory contents preserved.
